prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 181 ++++++++++++++++++
 tb/tb_prog_loader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Host-link program loader: parses SYNC/COUNT/word-pair/CHK frames and
// streams instruction words into program memory while holding the CPU.
module prog_loader #(
    parameter int WIDTH      = 13,
    parameter int IWIDTH     = 5,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [ADDR_WIDTH-1:0] P_MEM_ADDR,
    output logic [WIDTH-1:0]      P_MEM_DATA,
    output logic                  P_MEM_WE,
    output logic                  CPU_HOLD,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [7:0]            WORD_CNT
);

    localparam int OPW = WIDTH - IWIDTH;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_OPC,
        S_OPR,
        S_CHK,
        S_FIN
    } state_e;

    state_e state_q, state_d;

    logic [7:0]            xor_q, xor_d;
    logic [7:0]            n_q, n_d;
    logic [IWIDTH-1:0]     opc_q, opc_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  hold_q, hold_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      data_q, data_d;

    logic acc;
    logic opc_bad;
    logic chk_ok;
    logic last_word;

    assign acc       = IN_VALID && IN_READY;
    assign opc_bad   = (IN_DATA >> IWIDTH) != 8'd0;
    assign chk_ok    = IN_DATA == xor_q;
    assign last_word = (cnt_q + 8'd1) == n_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc && IN_DATA == SYNC_BYTE) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (acc) state_d = (IN_DATA == 8'd0) ? S_CHK : S_OPC;
            end
            S_OPC: begin
                if (acc) state_d = opc_bad ? S_IDLE : S_OPR;
            end
            S_OPR: begin
                if (acc) state_d = last_word ? S_CHK : S_OPC;
            end
            S_CHK: begin
                if (acc) state_d = chk_ok ? S_FIN : S_IDLE;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        IN_READY = state_q != S_FIN;
        BUSY     = state_q != S_IDLE;
        DONE     = state_q == S_FIN;
    end

    // Datapath next-state; the write is registered so it lands one cycle after OPR
    always_comb begin
        xor_d  = xor_q;
        n_d    = n_q;
        opc_d  = opc_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        we_d   = 1'b0;
        err_d  = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (acc) begin
            unique case (state_q)
                S_IDLE: begin
                    if (IN_DATA == SYNC_BYTE) begin
                        hold_d = 1'b1;
                        xor_d  = 8'd0;
                        cnt_d  = 8'd0;
                    end
                end
                S_COUNT: begin
                    n_d   = IN_DATA;
                    xor_d = xor_q ^ IN_DATA;
                end
                S_OPC: begin
                    if (opc_bad) begin
                        err_d = 1'b1;
                    end else begin
                        opc_d = IN_DATA[IWIDTH-1:0];
                        xor_d = xor_q ^ IN_DATA;
                    end
                end
                S_OPR: begin
                    xor_d  = xor_q ^ IN_DATA;
                    we_d   = 1'b1;
                    addr_d = ADDR_WIDTH'(cnt_q);
                    data_d = {opc_q, IN_DATA[OPW-1:0]};
                    cnt_d  = cnt_q + 8'd1;
                end
                S_CHK: begin
                    if (chk_ok) begin
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            xor_q  <= 8'd0;
            n_q    <= 8'd0;
            opc_q  <= '0;
            cnt_q  <= 8'd0;
            hold_q <= 1'b1;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            xor_q  <= xor_d;
            n_q    <= n_d;
            opc_q  <= opc_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            we_q   <= we_d;
            err_q  <= err_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign P_MEM_ADDR = addr_q;
    assign P_MEM_DATA = data_q;
    assign P_MEM_WE   = we_q;
    assign CPU_HOLD   = hold_q;
    assign ERR        = err_q;
    assign WORD_CNT   = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame table, hand-written reset sequence and
// random byte streams checked cycle by cycle against a frame-parser model.
module tb_prog_loader;

    logic        CLK;
    logic        RST;
    logic [7:0]  IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  P_MEM_ADDR;
    logic [12:0] P_MEM_DATA;
    logic        P_MEM_WE;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [7:0]  WORD_CNT;

    prog_loader dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .P_MEM_ADDR(P_MEM_ADDR),
        .P_MEM_DATA(P_MEM_DATA),
        .P_MEM_WE  (P_MEM_WE),
        .CPU_HOLD  (CPU_HOLD),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .WORD_CNT  (WORD_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit        sync;
        bit        we;
        bit [12:0] data;
        bit        done;
        bit        err;
    } eff_t;

    typedef struct {
        bit [95:0] bs;
        int        len;
        int        nwr;
        int        ndone;
        int        nerr;
        bit        hold;
        int        wc;
        bit [12:0] d0;
        bit [12:0] d1;
    } vec_t;

    int n_tot = 0;
    int n_pass = 0;

    byte unsigned stm[$];
    eff_t eff[];

    // model state carried across streams
    bit        m_hold;
    int        m_wc;
    bit [7:0]  e_addr;
    bit [12:0] e_data;

    int        nwr_seen, nd_seen, ne_seen;
    bit [12:0] wd[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Walk the byte stream as frames and mark what each byte should cause
    function automatic void build();
        int n;
        int i;
        n = stm.size();
        i = 0;
        eff = new[n];
        while (i < n) begin
            int nn;
            byte unsigned x;
            byte unsigned op;
            bit bad;
            if (stm[i] != 8'hA5) begin
                i++;
                continue;
            end
            eff[i].sync = 1'b1;
            i++;
            if (i >= n) break;
            nn = int'(stm[i]);
            x = stm[i];
            i++;
            bad = 1'b0;
            for (int k = 0; k < nn; k++) begin
                if (i >= n) begin
                    bad = 1'b1;
                    break;
                end
                op = stm[i];
                if (op > 8'h1F) begin
                    eff[i].err = 1'b1;
                    i++;
                    bad = 1'b1;
                    break;
                end
                x ^= op;
                i++;
                if (i >= n) begin
                    bad = 1'b1;
                    break;
                end
                x ^= stm[i];
                eff[i].we = 1'b1;
                eff[i].data = {op[4:0], stm[i]};
                i++;
            end
            if (bad || i >= n) continue;
            if (stm[i] == x) eff[i].done = 1'b1;
            else eff[i].err = 1'b1;
            i++;
        end
    endfunction

    task automatic check_cycle(input bit have, input eff_t p);
        if (have && p.sync) begin
            m_hold = 1'b1;
            m_wc = 0;
        end
        if (have && p.we) begin
            e_addr = 8'(m_wc);
            e_data = p.data;
            m_wc++;
        end
        if (have && p.done) m_hold = 1'b0;
        chk("we", P_MEM_WE, have && p.we);
        chk("done", DONE, have && p.done);
        chk("err", ERR, have && p.err);
        chk("hold", CPU_HOLD, m_hold);
        chk("word_cnt", WORD_CNT, m_wc);
        chk("addr", P_MEM_ADDR, e_addr);
        chk("data", P_MEM_DATA, e_data);
        if (have && p.done) begin
            chk("fin_ready", IN_READY, 1'b0);
            chk("fin_busy", BUSY, 1'b1);
        end
        if (P_MEM_WE) begin
            if (nwr_seen < 2) wd[nwr_seen] = P_MEM_DATA;
            nwr_seen++;
        end
        if (DONE) nd_seen++;
        if (ERR) ne_seen++;
    endtask

    task automatic run(input int pv);
        int i;
        int cyc;
        bit have;
        eff_t pend;
        i = 0;
        cyc = 0;
        have = 1'b0;
        pend = '{default: 0};
        nwr_seen = 0;
        nd_seen = 0;
        ne_seen = 0;
        build();
        while ((i < stm.size() || have) && cyc < 20000) begin
            @(negedge CLK);
            cyc++;
            check_cycle(have, pend);
            have = 1'b0;
            if (i < stm.size() && $urandom_range(99) < pv) begin
                IN_VALID = 1'b1;
                IN_DATA = stm[i];
                if (IN_READY) begin
                    pend = eff[i];
                    have = 1'b1;
                    i++;
                end
            end else begin
                IN_VALID = 1'b0;
            end
        end
        chk("stream_drained", i, stm.size());
        IN_VALID = 1'b0;
    endtask

    task automatic do_reset();
        IN_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        m_hold = 1'b1;
        m_wc = 0;
        e_addr = '0;
        e_data = '0;
    endtask

    task automatic load_vec(input vec_t v);
        stm.delete();
        for (int k = 0; k < v.len; k++) stm.push_back(v.bs[8*(v.len-1-k) +: 8]);
    endtask

    function automatic vec_t mkv(input bit [95:0] bs, input int len, input int nwr,
                                 input int nd, input int ne, input bit h, input int wc,
                                 input bit [12:0] d0, input bit [12:0] d1);
        vec_t v;
        v.bs = bs;
        v.len = len;
        v.nwr = nwr;
        v.ndone = nd;
        v.nerr = ne;
        v.hold = h;
        v.wc = wc;
        v.d0 = d0;
        v.d1 = d1;
        return v;
    endfunction

    vec_t vt[6];

    initial begin
        vt[0] = mkv(96'hA5020C0507000C, 7, 2, 1, 0, 1'b0, 2, 13'h0C05, 13'h0700);
        vt[1] = mkv(96'hA5020C0507000D, 7, 2, 0, 1, 1'b1, 2, 13'h0C05, 13'h0700);
        vt[2] = mkv(96'hA5012C05, 4, 0, 0, 1, 1'b1, 0, 13'h0, 13'h0);
        vt[3] = mkv(96'h1122A50000, 5, 0, 1, 0, 1'b0, 0, 13'h0, 13'h0);
        vt[4] = mkv(96'hA5011FFFE1, 5, 1, 1, 0, 1'b0, 1, 13'h1FFF, 13'h0);
        vt[5] = mkv(96'hA5021F0020, 5, 1, 0, 1, 1'b1, 1, 13'h1F00, 13'h0);

        IN_DATA = 8'h00;
        IN_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_hold", CPU_HOLD, 1'b1);
        chk("rst_we", P_MEM_WE, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_wc", WORD_CNT, 8'd0);
        chk("rst_addr", P_MEM_ADDR, 8'd0);
        chk("rst_data", P_MEM_DATA, 13'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ready", IN_READY, 1'b1);
        do_reset();

        for (int pass = 0; pass < 2; pass++) begin
            for (int t = 0; t < 6; t++) begin
                load_vec(vt[t]);
                run(pass == 0 ? 100 : 50);
                chk("vec_nwr", nwr_seen, vt[t].nwr);
                chk("vec_ndone", nd_seen, vt[t].ndone);
                chk("vec_nerr", ne_seen, vt[t].nerr);
                chk("vec_hold", CPU_HOLD, vt[t].hold);
                chk("vec_wc", WORD_CNT, vt[t].wc);
                if (vt[t].nwr > 0) chk("vec_d0", wd[0], vt[t].d0);
                if (vt[t].nwr > 1) chk("vec_d1", wd[1], vt[t].d1);
            end
        end

        // reset right after the first OPR handshake cancels its write
        do_reset();
        IN_VALID = 1'b1;
        @(negedge CLK); IN_DATA = 8'hA5;
        @(negedge CLK); IN_DATA = 8'h02;
        @(negedge CLK); IN_DATA = 8'h0C;
        @(negedge CLK); IN_DATA = 8'h05;
        chk("mid_busy", BUSY, 1'b1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("mid_rst_we", P_MEM_WE, 1'b0);
        chk("mid_rst_hold", CPU_HOLD, 1'b1);
        chk("mid_rst_wc", WORD_CNT, 8'd0);
        chk("mid_rst_busy", BUSY, 1'b0);
        chk("mid_rst_addr", P_MEM_ADDR, 8'd0);
        chk("mid_rst_data", P_MEM_DATA, 13'd0);
        @(negedge CLK);
        chk("mid_rst_we2", P_MEM_WE, 1'b0);
        RST = 1'b0;
        m_hold = 1'b1;
        m_wc = 0;
        e_addr = '0;
        e_data = '0;
        load_vec(vt[0]);
        run(100);
        chk("after_rst_nwr", nwr_seen, 2);
        chk("after_rst_d0", wd[0], 13'h0C05);
        chk("after_rst_d1", wd[1], 13'h0700);
        chk("after_rst_done", nd_seen, 1);
        chk("after_rst_hold", CPU_HOLD, 1'b0);

        // random frames with occasional bad opcodes and bad checksums
        stm.delete();
        for (int f = 0; f < 40; f++) begin
            int nn;
            byte unsigned x;
            byte unsigned b;
            if ($urandom_range(3) == 0) begin
                b = 8'($urandom_range(255));
                if (b == 8'hA5) b = 8'h00;
                stm.push_back(b);
            end
            stm.push_back(8'hA5);
            nn = $urandom_range(5);
            stm.push_back(8'(nn));
            x = 8'(nn);
            for (int k = 0; k < nn; k++) begin
                if ($urandom_range(9) == 0) b = 8'($urandom_range(255, 32));
                else b = 8'($urandom_range(31));
                stm.push_back(b);
                x ^= b;
                b = 8'($urandom_range(255));
                stm.push_back(b);
                x ^= b;
            end
            if ($urandom_range(4) == 0) x ^= 8'(1 << $urandom_range(7));
            stm.push_back(x);
        end
        run(70);
        do_reset();
        @(negedge CLK);
        chk("final_hold", CPU_HOLD, 1'b1);
        chk("final_wc", WORD_CNT, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
